// File: rtl/execute_muldiv_if.sv
// Execute-stage handshake bundle between the pipeline and the RV32M multiply/divide unit.
interface execute_muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start_E;
   logic [2:0]       op_E;
   logic [WIDTH-1:0] srcA_E;
   logic [WIDTH-1:0] srcB_E;
   logic [4:0]       Rd_E;
   logic             flush_E;
   logic [WIDTH-1:0] result_E;
   logic [4:0]       Rd_out_E;
   logic             done_E;
   logic             busy_E;
   logic             stall_E;

   modport master (
      output start_E, op_E, srcA_E, srcB_E, Rd_E, flush_E,
      input  result_E, Rd_out_E, done_E, busy_E, stall_E
   );

   modport slave (
      input  start_E, op_E, srcA_E, srcB_E, Rd_E, flush_E,
      output result_E, Rd_out_E, done_E, busy_E, stall_E
   );
endinterface

// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M unit: 2-cycle multiply, 32-step restoring divide, stalls the front end while busy.
module execute_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic              clk,
   input  logic              rst,
   execute_muldiv_if.slave   bus
);
   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV_ITER, S_DIV_FIX, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic [4:0]         rd_q, rd_d;
   logic [WIDTH-1:0]   dvd_q, dvd_d;     // multiplicand, or dividend being shifted out
   logic [WIDTH-1:0]   dvs_q, dvs_d;     // multiplier, or divisor magnitude
   logic [WIDTH-1:0]   rem_q, rem_d;
   logic [WIDTH-1:0]   quo_q, quo_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               qneg_q, qneg_d;
   logic               rneg_q, rneg_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic               sgn_div;
   logic               mul_sa, mul_sb;
   logic [2*WIDTH-1:0] mul_a, mul_b, prod;
   logic [WIDTH:0]     rem_shift, rem_sub;
   logic [WIDTH-1:0]   q_fix, r_fix;

   function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
      return ~x + WIDTH'(1);
   endfunction

   // Extending to 2*WIDTH makes one unsigned multiply serve all four sign modes.
   assign mul_sa    = (op_q == 2'b01) || (op_q == 2'b10);
   assign mul_sb    = (op_q == 2'b01);
   assign mul_a     = {{WIDTH{mul_sa & dvd_q[WIDTH-1]}}, dvd_q};
   assign mul_b     = {{WIDTH{mul_sb & dvs_q[WIDTH-1]}}, dvs_q};
   assign prod      = mul_a * mul_b;

   // One extra bit so the compare stays exact for divisors above 2^(WIDTH-1).
   assign rem_shift = {rem_q, dvd_q[WIDTH-1]};
   assign rem_sub   = rem_shift - {1'b0, dvs_q};
   assign q_fix     = qneg_q ? neg(quo_q) : quo_q;
   assign r_fix     = rneg_q ? neg(rem_q) : rem_q;
   assign sgn_div   = ~bus.op_E[0];

   always_comb begin
      // NOTE: every next-state value defaults to its register so no path infers a latch.
      state_d  = state_q;
      op_d     = op_q;
      rd_d     = rd_q;
      dvd_d    = dvd_q;
      dvs_d    = dvs_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      cnt_d    = cnt_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      result_d = result_q;

      unique case (state_q)
         S_IDLE: begin
            if (bus.start_E && !bus.flush_E) begin
               op_d = bus.op_E[1:0];
               rd_d = bus.Rd_E;
               if (!bus.op_E[2]) begin
                  dvd_d   = bus.srcA_E;
                  dvs_d   = bus.srcB_E;
                  state_d = S_MUL;
               end else if (bus.srcB_E == '0) begin
                  result_d = bus.op_E[1] ? bus.srcA_E : '1;
                  state_d  = S_DONE;
               end else if (sgn_div && bus.srcA_E == MIN_NEG && bus.srcB_E == '1) begin
                  result_d = bus.op_E[1] ? '0 : MIN_NEG;
                  state_d  = S_DONE;
               end else begin
                  dvd_d   = (sgn_div && bus.srcA_E[WIDTH-1]) ? neg(bus.srcA_E) : bus.srcA_E;
                  dvs_d   = (sgn_div && bus.srcB_E[WIDTH-1]) ? neg(bus.srcB_E) : bus.srcB_E;
                  qneg_d  = sgn_div & (bus.srcA_E[WIDTH-1] ^ bus.srcB_E[WIDTH-1]);
                  rneg_d  = sgn_div & bus.srcA_E[WIDTH-1];
                  rem_d   = '0;
                  quo_d   = '0;
                  cnt_d   = CNT_W'(WIDTH-1);
                  state_d = S_DIV_ITER;
               end
            end
         end
         S_MUL: begin
            result_d = (op_q == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
            state_d  = S_DONE;
         end
         S_DIV_ITER: begin
            dvd_d = dvd_q << 1;
            if (!rem_sub[WIDTH]) begin
               rem_d = rem_sub[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               rem_d = rem_shift[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == '0) state_d = S_DIV_FIX;
         end
         S_DIV_FIX: begin
            result_d = op_q[1] ? r_fix : q_fix;
            state_d  = S_DONE;
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // An aborted instruction must leave the architecturally visible result untouched.
      if (bus.flush_E) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         rd_q     <= '0;
         dvd_q    <= '0;
         dvs_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         cnt_q    <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         // NOTE: non-blocking so every register samples the pre-edge values of the others.
         state_q  <= state_d;
         op_q     <= op_d;
         rd_q     <= rd_d;
         dvd_q    <= dvd_d;
         dvs_q    <= dvs_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         cnt_q    <= cnt_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   assign bus.result_E = result_q;
   assign bus.Rd_out_E = rd_q;
   assign bus.done_E   = (state_q == S_DONE) && !bus.flush_E;
   assign bus.busy_E   = (state_q == S_MUL) || (state_q == S_DIV_ITER) || (state_q == S_DIV_FIX);
   assign bus.stall_E  = (bus.start_E && state_q == S_IDLE && !bus.flush_E) || bus.busy_E;
endmodule

// File: tb/tb_execute_muldiv.sv
// Directed scoreboard bench for execute_muldiv: latency, results, specials, flush, reset, handshake.
module tb_execute_muldiv;
   localparam int W = 32;

   typedef struct {
      logic [W-1:0] res;
      logic [4:0]   rd;
      int           lat;
   } exp_t;

   logic clk;
   logic rst;
   int   errors = 0;
   int   checks = 0;
   exp_t sb[$];
   logic [W-1:0] last_exp;

   execute_muldiv_if #(.WIDTH(W)) bus ();

   execute_muldiv #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drives one start in cycle 0; returns #1 after edge 0 with start_E low.
   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [4:0] rd, input string tag);
      bus.start_E = 1'b1;
      bus.op_E    = op;
      bus.srcA_E  = a;
      bus.srcB_E  = b;
      bus.Rd_E    = rd;
      @(negedge clk);
      check({tag, "_stall_c0"}, 64'(bus.stall_E), 64'd1);
      @(posedge clk);
      #1;
      bus.start_E = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int   n = 0;
      bit   got = 0;
      bit   stall_bad = 0;
      exp_t e;
      while (!got && n < 60) begin
         @(negedge clk);
         n++;
         if (bus.done_E) begin
            got = 1;
            if (sb.size() == 0) begin
               check({tag, "_sb_empty"}, 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               last_exp = e.res;
               check({tag, "_result"}, 64'(bus.result_E), 64'(e.res));
               check({tag, "_rd"}, 64'(bus.Rd_out_E), 64'(e.rd));
               check({tag, "_latency"}, 64'(n), 64'(e.lat));
               check({tag, "_stall_done"}, 64'(bus.stall_E), 64'd0);
            end
         end else if (!bus.stall_E) begin
            stall_bad = 1;
         end
      end
      if (!got) check({tag, "_timeout"}, 64'd0, 64'd1);
      else      check({tag, "_stall_busy"}, 64'(stall_bad), 64'd0);
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] rd, input logic [W-1:0] exp_res, input int lat,
                        input string tag);
      sb.push_back('{res: exp_res, rd: rd, lat: lat});
      start_op(op, a, b, rd, tag);
      wait_done(tag);
   endtask

   initial begin
      int           dones;
      logic [8:0]   mask;
      exp_t         e;

      rst         = 1'b0;
      bus.start_E = 1'b0;
      bus.op_E    = '0;
      bus.srcA_E  = '0;
      bus.srcB_E  = '0;
      bus.Rd_E    = '0;
      bus.flush_E = 1'b0;
      last_exp    = '0;

      // Reset state; stall follows start_E alone.
      #2;
      bus.start_E = 1'b1;
      #1;
      check("rst_stall_start", 64'(bus.stall_E), 64'd1);
      check("rst_result", 64'(bus.result_E), 64'd0);
      check("rst_rd", 64'(bus.Rd_out_E), 64'd0);
      check("rst_done", 64'(bus.done_E), 64'd0);
      check("rst_busy", 64'(bus.busy_E), 64'd0);
      bus.start_E = 1'b0;
      #1;
      check("rst_stall_idle", 64'(bus.stall_E), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Multiplies, back to back.
      issue(3'b000, 32'd7,        32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, 2,  "mul");
      issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd4, 32'h4000_0000, 2,  "mulh");
      issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5, 32'hFFFF_FFFF, 2,  "mulhsu");
      issue(3'b011, 32'h0001_0000, 32'h0003_0000, 5'd6, 32'h0000_0003, 2,  "mulhu_small");

      // Normal divides.
      issue(3'b100, 32'hFFFF_FFF9, 32'd2,        5'd7,  32'hFFFF_FFFD, 34, "div_neg");
      issue(3'b110, 32'hFFFF_FFF9, 32'd2,        5'd8,  32'hFFFF_FFFF, 34, "rem_neg");
      issue(3'b101, 32'd100,       32'd7,        5'd9,  32'd14,        34, "divu");
      issue(3'b111, 32'd100,       32'd7,        5'd10, 32'd2,         34, "remu");
      issue(3'b101, 32'hFFFF_FFFF, 32'h8000_0001, 5'd11, 32'd1,        34, "divu_big");
      issue(3'b111, 32'hFFFF_FFFF, 32'h8000_0001, 5'd12, 32'h7FFF_FFFE, 34, "remu_big");
      issue(3'b100, 32'h8000_0000, 32'd2,        5'd13, 32'hC000_0000, 34, "div_min2");

      // Special cases complete in one cycle.
      issue(3'b101, 32'd5,         32'd0,         5'd14, 32'hFFFF_FFFF, 1, "divu_zero");
      issue(3'b110, 32'd5,         32'd0,         5'd15, 32'd5,         1, "rem_zero");
      issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'h8000_0000, 1, "div_ovf");
      issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 32'd0,         1, "rem_ovf");

      // Flush at cycle 15 of a divide: no done, result kept.
      start_op(3'b101, 32'd1000, 32'd3, 5'd18, "flush_div");
      repeat (14) @(posedge clk);
      #1;
      bus.flush_E = 1'b1;
      @(posedge clk);
      #1;
      bus.flush_E = 1'b0;
      @(negedge clk);
      check("flush_busy", 64'(bus.busy_E), 64'd0);
      check("flush_result", 64'(bus.result_E), 64'(last_exp));
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_E) dones++;
      end
      check("flush_no_done", 64'(dones), 64'd0);
      @(posedge clk);
      #1;

      // Flush together with start in IDLE: start ignored.
      bus.start_E = 1'b1;
      bus.flush_E = 1'b1;
      bus.op_E    = 3'b000;
      bus.srcA_E  = 32'd2;
      bus.srcB_E  = 32'd2;
      bus.Rd_E    = 5'd19;
      @(negedge clk);
      check("flush_start_stall", 64'(bus.stall_E), 64'd0);
      @(posedge clk);
      #1;
      bus.start_E = 1'b0;
      bus.flush_E = 1'b0;
      dones = 0;
      repeat (5) begin
         @(negedge clk);
         if (bus.done_E || bus.busy_E) dones++;
      end
      check("flush_start_ignored", 64'(dones), 64'd0);
      @(posedge clk);
      #1;

      // Start held high across DONE: one more op accepted at cycle 3, nothing else.
      sb.push_back('{res: 32'd42, rd: 5'd20, lat: 2});
      sb.push_back('{res: 32'd42, rd: 5'd20, lat: 5});
      bus.start_E = 1'b1;
      bus.op_E    = 3'b000;
      bus.srcA_E  = 32'd6;
      bus.srcB_E  = 32'd7;
      bus.Rd_E    = 5'd20;
      mask        = '0;
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         if (c == 2) check("hs_stall_done", 64'(bus.stall_E), 64'd0);
         if (bus.done_E) begin
            mask[c] = 1'b1;
            if (sb.size() == 0) begin
               check("hs_sb_empty", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               last_exp = e.res;
               check("hs_result", 64'(bus.result_E), 64'(e.res));
               check("hs_rd", 64'(bus.Rd_out_E), 64'(e.rd));
            end
         end
         @(posedge clk);
         #1;
         if (c == 3) bus.start_E = 1'b0;
      end
      check("hs_done_cycles", 64'(mask), 64'(9'b0_0010_0100));
      check("hs_sb_drained", 64'(sb.size()), 64'd0);

      // Asynchronous reset in the middle of a divide.
      start_op(3'b100, 32'd100, 32'd7, 5'd21, "rst_div");
      repeat (9) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("midrst_result", 64'(bus.result_E), 64'd0);
      check("midrst_rd", 64'(bus.Rd_out_E), 64'd0);
      check("midrst_done", 64'(bus.done_E), 64'd0);
      check("midrst_busy", 64'(bus.busy_E), 64'd0);
      check("midrst_stall", 64'(bus.stall_E), 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      dones = 0;
      repeat (40) begin
         @(negedge clk);
         if (bus.done_E) dones++;
      end
      check("midrst_no_done", 64'(dones), 64'd0);
      @(posedge clk);
      #1;
      issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd22, 32'hFFFF_FFFE, 2, "mulhu_after_rst");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
